// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// i2c_target_regs
// I2C target (responder) that exposes a byte-addressed register space to the
// user side. A write transaction sets the register pointer from its first data
// byte and writes any further bytes at auto-incrementing addresses. A read
// transaction streams bytes starting at the current pointer. The pads are
// open-drain: the block only ever pulls SDA low, and it never stretches SCL.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   scl_in      raw SCL pad level
//   sda_in      raw SDA pad level
//   sda_out     SDA drive value (always 0, open-drain)
//   sda_enable  1 = pull SDA low
//   reg_addr    current register pointer
//   wr_data     byte being written
//   wr_strobe   one-cycle write pulse; reg_addr/wr_data valid in the same cycle
//   rd_strobe   one-cycle read request for reg_addr
//   rd_data     read byte, valid exactly one clk after rd_strobe
//   busy        1 while addressed (matched address until STOP/START/NACK)
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_W     = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_out,
    output logic              sda_enable,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        wr_data,
    output logic              wr_strobe,
    output logic              rd_strobe,
    input  logic [7:0]        rd_data,
    output logic              busy
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(FILTER_LEN - 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    // Line index 0 is SCL, index 1 is SDA.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [1:0]       filt_d;
    logic [CNT_W-1:0] flt_cnt [2];

    logic [3:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic              rw;
    logic              rd_capture;
    logic [ADDR_W-1:0] ptr;

    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_cond;
    logic stop_cond;
    logic sda_f;

    assign sda_out  = 1'b0;
    assign reg_addr = ptr;

    // The filtered level only flips once the synchronized input has disagreed
    // with it for FILTER_LEN consecutive samples; any agreeing sample restarts
    // the count, so short glitches never reach the bit logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                flt_cnt[i] <= '0;
            end
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sda_f    = filt[1];
    assign scl_rise =  filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] &  filt_d[0];
    assign sda_rise =  filt[1] & ~filt_d[1];
    assign sda_fall = ~filt[1] &  filt_d[1];
    // SCL must have been high on both sides of the SDA edge.
    assign start_cond = sda_fall & filt[0] & filt_d[0];
    assign stop_cond  = sda_rise & filt[0] & filt_d[0];

    // Protocol engine. Bits are sampled on filtered SCL rises; every change of
    // sda_enable is registered off a filtered SCL fall, so SDA only moves
    // while SCL is low. START/STOP override everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rw         <= 1'b0;
            rd_capture <= 1'b0;
            ptr        <= '0;
            sda_enable <= 1'b0;
            busy       <= 1'b0;
            wr_data    <= '0;
            wr_strobe  <= 1'b0;
            rd_strobe  <= 1'b0;
        end else begin
            wr_strobe  <= 1'b0;
            rd_strobe  <= 1'b0;
            rd_capture <= rd_strobe;

            // The pointer moves on the cycle after the write strobe so the
            // user side sees the address the byte belongs to.
            if (wr_strobe) begin
                ptr <= ptr + 1'b1;
            end

            if (start_cond || stop_cond) begin
                state      <= start_cond ? ST_ADDR : ST_IDLE;
                bit_cnt    <= '0;
                sda_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shift[7:1] == DEV_ADDR) begin
                                sda_enable <= 1'b1;
                                busy       <= 1'b1;
                                rw         <= shift[0];
                                state      <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    // For a read, SDA stays pulled low after the ACK until
                    // the first byte arrives from the user side; the bit-7
                    // level is then applied a few clocks into SCL low, well
                    // ahead of the next rise.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                rd_strobe <= 1'b1;
                                state     <= ST_RDATA;
                            end else begin
                                sda_enable <= 1'b0;
                                state      <= ST_PTR;
                            end
                        end
                    end

                    ST_PTR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt    <= '0;
                            sda_enable <= 1'b1;
                            state      <= ST_PTR_ACK;
                        end
                    end

                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            sda_enable <= 1'b0;
                            ptr        <= shift[ADDR_W-1:0];
                            state      <= ST_WDATA;
                        end
                    end

                    ST_WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_f};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt    <= '0;
                            sda_enable <= 1'b1;
                            wr_strobe  <= 1'b1;
                            wr_data    <= shift;
                            state      <= ST_WDATA_ACK;
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_enable <= 1'b0;
                            state      <= ST_WDATA;
                        end
                    end

                    // bit_cnt counts the bits the master has clocked out;
                    // after the eighth, SDA is released for its ACK.
                    ST_RDATA: begin
                        if (rd_capture) begin
                            shift      <= rd_data;
                            sda_enable <= ~rd_data[7];
                            bit_cnt    <= '0;
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt    <= '0;
                                sda_enable <= 1'b0;
                                state      <= ST_RDATA_ACK;
                            end else begin
                                shift      <= {shift[6:0], 1'b0};
                                sda_enable <= ~shift[6];
                            end
                        end
                    end

                    // A NACK leaves at the rise, so a fall seen here always
                    // follows an ACK.
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                ptr <= ptr + 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IGNORE;
                            end
                        end else if (scl_fall) begin
                            rd_strobe <= 1'b1;
                            state     <= ST_RDATA;
                        end
                    end

                    default: begin
                        sda_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Testbench for i2c_target_regs: a bit-banged I2C master on a wired-AND bus,
// a register-file model answering read strobes with addr ^ 0xFF one clock
// later, and a log of every write strobe.
module tb_i2c_target_regs;

    localparam int Q = 25;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
        int         exp_n;
        logic [7:0] a0;
        logic [7:0] w0;
        logic [7:0] a1;
        logic [7:0] w1;
        logic [7:0] fin;
    } wr_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       scl_glitch;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic       sda_enable;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       rd_strobe;
    logic [7:0] rd_data;
    logic       busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];
    int         rd_count    = 0;
    int         busy_cycles = 0;
    logic       rd_pend     = 1'b0;
    logic [7:0] rd_addr_q   = 8'h00;

    always #5 clk = ~clk;

    assign scl_in = scl_m ^ scl_glitch;
    assign sda_in = sda_m & ~sda_enable;

    i2c_target_regs #(
        .DEV_ADDR  (7'h50),
        .ADDR_W    (8),
        .FILTER_LEN(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_out   (sda_out),
        .sda_enable(sda_enable),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // Register-file model: rd_data holds the addressed byte only during the
    // clock right after rd_strobe, and junk otherwise.
    always @(negedge clk) begin
        if (rd_pend) begin
            rd_data = rd_addr_q ^ 8'hFF;
            rd_pend = 1'b0;
        end else begin
            rd_data = 8'h5A;
        end
        if (rd_strobe) begin
            rd_pend   = 1'b1;
            rd_addr_q = reg_addr;
            rd_count  = rd_count + 1;
        end
    end

    always @(negedge clk) begin
        if (wr_strobe) begin
            log_addr.push_back(reg_addr);
            log_data.push_back(wr_data);
        end
        if (busy) begin
            busy_cycles = busy_cycles + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_cnt = total_cnt + 1;
        if (actual === expected) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic glitch_q();
        repeat (Q / 2) @(negedge clk);
        scl_glitch = 1'b1;
        @(negedge clk);
        scl_glitch = 1'b0;
        repeat (Q - Q / 2 - 1) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    // glitch: 0 none, 1 one-clock SCL pulse while low, 2 one-clock dip while high
    task automatic send_bit(input logic b, input int glitch);
        sda_m = b;
        if (glitch == 1) glitch_q(); else wait_q();
        scl_m = 1'b1;
        if (glitch == 2) glitch_q(); else wait_q();
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        b = sda_in;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, input int glow, input int ghigh,
                             output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], (i == glow) ? 1 : ((i == ghigh) ? 2 : 0));
        end
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack, 0);
    endtask

    task automatic applyStimulus(input wr_vec_t v, output logic [3:0] acks);
        logic a0, a1, a2, a3;
        bus_start();
        send_byte(v.dev, -1, -1, a0);
        send_byte(v.ptr, -1, -1, a1);
        send_byte(v.d0, -1, -1, a2);
        send_byte(v.d1, -1, -1, a3);
        bus_stop();
        acks = {a0, a1, a2, a3};
    endtask

    task automatic check_strobe(input string name, input int idx,
                                input logic [7:0] ea, input logic [7:0] ew);
        logic [31:0] ga;
        logic [31:0] gw;
        ga = (idx < log_addr.size()) ? 32'(log_addr[idx]) : 32'hDEAD;
        gw = (idx < log_data.size()) ? 32'(log_data[idx]) : 32'hDEAD;
        checkOutput({name, " addr"}, ga, 32'(ea));
        checkOutput({name, " data"}, gw, 32'(ew));
    endtask

    wr_vec_t    vecs [4];
    logic [3:0] acks;
    logic       ack;
    logic [7:0] rb;
    int         base;
    int         bc0;
    int         rc0;

    initial begin
        vecs[0] = '{8'hA0, 8'h10, 8'hA5, 8'h3C, 1'b1, 2, 8'h10, 8'hA5, 8'h11, 8'h3C, 8'h12};
        vecs[1] = '{8'hA2, 8'h10, 8'h55, 8'h66, 1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12};
        vecs[2] = '{8'hA0, 8'hFF, 8'h11, 8'h22, 1'b1, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 8'h01};
        vecs[3] = '{8'hA0, 8'h7F, 8'h00, 8'hFF, 1'b1, 2, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'h81};

        reset      = 1'b1;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        scl_glitch = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("reset sda_enable", 32'(sda_enable), 32'd0);
        checkOutput("reset wr_strobe", 32'(wr_strobe), 32'd0);
        checkOutput("reset rd_strobe", 32'(rd_strobe), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset wr_data", 32'(wr_data), 32'd0);
        checkOutput("reset reg_addr", 32'(reg_addr), 32'd0);
        checkOutput("reset sda_out", 32'(sda_out), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Write transactions from the vector table.
        for (int v = 0; v < 4; v++) begin
            base = log_addr.size();
            bc0  = busy_cycles;
            applyStimulus(vecs[v], acks);
            checkOutput($sformatf("vec%0d acks", v), 32'(acks), vecs[v].exp_ack ? 32'hF : 32'h0);
            checkOutput($sformatf("vec%0d strobe count", v), 32'(log_addr.size() - base),
                        32'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0) check_strobe($sformatf("vec%0d strobe0", v), base, vecs[v].a0, vecs[v].w0);
            if (vecs[v].exp_n > 1) check_strobe($sformatf("vec%0d strobe1", v), base + 1, vecs[v].a1, vecs[v].w1);
            checkOutput($sformatf("vec%0d reg_addr", v), 32'(reg_addr), 32'(vecs[v].fin));
            checkOutput($sformatf("vec%0d busy seen", v), 32'(busy_cycles > bc0), 32'(vecs[v].exp_ack));
            checkOutput($sformatf("vec%0d busy after stop", v), 32'(busy), 32'd0);
            checkOutput($sformatf("vec%0d sda_enable idle", v), 32'(sda_enable), 32'd0);
        end

        // Pointer write, repeated START, read three bytes (ACK, ACK, NACK).
        base = log_addr.size();
        rc0  = rd_count;
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        checkOutput("read: addr W ack", 32'(ack), 32'd1);
        send_byte(8'h20, -1, -1, ack);
        checkOutput("read: ptr ack", 32'(ack), 32'd1);
        bus_rstart();
        send_byte(8'hA1, -1, -1, ack);
        checkOutput("read: addr R ack", 32'(ack), 32'd1);
        recv_byte(rb, 1'b1);
        checkOutput("read: byte0", 32'(rb), 32'hDF);
        checkOutput("read: busy mid", 32'(busy), 32'd1);
        recv_byte(rb, 1'b1);
        checkOutput("read: byte1", 32'(rb), 32'hDE);
        recv_byte(rb, 1'b0);
        checkOutput("read: byte2", 32'(rb), 32'hDD);
        checkOutput("read: sda released after nack", 32'(sda_enable), 32'd0);
        bus_stop();
        checkOutput("read: busy after stop", 32'(busy), 32'd0);
        checkOutput("read: rd_strobe count", 32'(rd_count - rc0), 32'd3);
        checkOutput("read: no wr_strobe", 32'(log_addr.size() - base), 32'd0);
        checkOutput("read: reg_addr", 32'(reg_addr), 32'h22);

        // STOP after four bits of a data byte, then a pointer-only write.
        base = log_addr.size();
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        send_byte(8'h40, -1, -1, ack);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        bus_stop();
        checkOutput("partial: no wr_strobe", 32'(log_addr.size() - base), 32'd0);
        checkOutput("partial: sda_enable", 32'(sda_enable), 32'd0);
        checkOutput("partial: busy", 32'(busy), 32'd0);
        checkOutput("partial: reg_addr", 32'(reg_addr), 32'h40);
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        send_byte(8'h33, -1, -1, ack);
        bus_stop();
        checkOutput("ptr-only: no wr_strobe", 32'(log_addr.size() - base), 32'd0);
        checkOutput("ptr-only: reg_addr", 32'(reg_addr), 32'h33);

        // One-clock SCL glitches while low and while high.
        base = log_addr.size();
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        send_byte(8'h50, -1, -1, ack);
        send_byte(8'hC3, 4, 2, ack);
        checkOutput("glitch: data ack", 32'(ack), 32'd1);
        send_byte(8'h18, -1, -1, ack);
        bus_stop();
        checkOutput("glitch: strobe count", 32'(log_addr.size() - base), 32'd2);
        check_strobe("glitch: strobe0", base, 8'h50, 8'hC3);
        check_strobe("glitch: strobe1", base + 1, 8'h51, 8'h18);

        // Reset while driving a read bit of 0, then a normal write.
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        send_byte(8'h90, -1, -1, ack);
        bus_rstart();
        send_byte(8'hA1, -1, -1, ack);
        checkOutput("rst: driving bit7=0", 32'(sda_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst: sda released", 32'(sda_enable), 32'd0);
        checkOutput("rst: reg_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_q();
        wait_q();
        base = log_addr.size();
        bus_start();
        send_byte(8'hA0, -1, -1, ack);
        checkOutput("post-rst: addr ack", 32'(ack), 32'd1);
        send_byte(8'h05, -1, -1, ack);
        send_byte(8'h77, -1, -1, ack);
        checkOutput("post-rst: data ack", 32'(ack), 32'd1);
        bus_stop();
        checkOutput("post-rst: strobe count", 32'(log_addr.size() - base), 32'd1);
        check_strobe("post-rst: strobe0", base, 8'h05, 8'h77);
        checkOutput("post-rst: reg_addr", 32'(reg_addr), 32'h06);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
